// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath: product width and the
// accumulator FSM state encodings.
package mult_pkg;

  localparam int PROD_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACCUM = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating adder: unsigned accumulator plus an unsigned product,
// clamping to all-ones and flagging when the sum does not fit in ACC_W bits.
module sat_adder
  import mult_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a} + {{(ACC_W - PROD_W + 1){1'b0}}, b};
  assign sat      = full_sum[ACC_W];
  assign sum      = sat ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates TERMS multiplier products into a saturating sum and offers the
// result on a valid/ready port, holding it until consumed.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first product of a new result
//   ST_ACCUM | adding further products until TERMS have been accepted
//   ST_DONE  | result presented on res_data, waiting for res_ready
module product_accumulator
  import mult_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int TERMS = 4,
  parameter int CNT_W = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic [CNT_W-1:0]  term_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(TERMS - 1);
  localparam logic [1:0]       FIRST_NEXT = (TERMS == 1) ? ST_DONE : ST_ACCUM;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic             sat_q;
  logic [CNT_W-1:0] cnt;
  logic             prod_hs;
  logic             res_hs;

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .a   (acc),
    .b   (prod),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign prod_ready = ena & (state != ST_DONE);
  assign res_valid  = ena & (state == ST_DONE);
  assign prod_hs    = prod_valid & prod_ready;
  assign res_hs     = res_valid & res_ready;

  assign res_data = acc;
  assign res_sat  = sat_q;
  assign term_cnt = cnt;

  // clear outranks both handshakes; ena low freezes everything including clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      sat_q <= 1'b0;
      cnt   <= '0;
    end else if (ena) begin
      if (clear) begin
        state <= ST_IDLE;
        acc   <= '0;
        sat_q <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (prod_hs) begin
              acc   <= {{(ACC_W - PROD_W){1'b0}}, prod};
              sat_q <= 1'b0;
              cnt   <= CNT_W'(1);
              state <= FIRST_NEXT;
            end
          end
          ST_ACCUM: begin
            if (prod_hs) begin
              acc   <= add_sum;
              sat_q <= sat_q | add_sat;
              cnt   <= cnt + CNT_W'(1);
              if (cnt == LAST_IDX) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (res_hs) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
